// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the I/O decoder.
// The master modport is the arbiter's view; slave is the masters/peripheral side.
interface io_bus_arbiter_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_ack;
   logic          m0_err;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_ack;
   logic          m1_err;
   logic [DW-1:0] m1_rdata;

   logic          io_rd;
   logic          io_wr;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_dout;
   logic [DW-1:0] io_din;
   logic          io_ready;
   logic          busy;

   modport master (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  io_din, io_ready,
      output m0_ack, m0_err, m0_rdata,
      output m1_ack, m1_err, m1_rdata,
      output io_rd, io_wr, io_addr, io_dout, busy
   );

   modport slave (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output io_din, io_ready,
      input  m0_ack, m0_err, m0_rdata,
      input  m1_ack, m1_err, m1_rdata,
      input  io_rd, io_wr, io_addr, io_dout, busy
   );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the I/O bus, one transaction at a time,
// with io_ready wait states and a timeout abort that reports an error.
module io_bus_arbiter #(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CW      = 4
) (
   input logic          clk,
   input logic          reset,
   io_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] dout_q, dout_d;
   logic [1:0]    ack_q, ack_d;
   logic [1:0]    err_q, err_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          pick;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      ack_d    = '0;
      err_d    = '0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      pick     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.m0_req || bus.m1_req) begin
               // On a tie the master that did not win last time goes next.
               pick    = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
               gnt_d   = pick;
               last_d  = pick;
               cnt_d   = '0;
               state_d = StAccess;
               if (pick) begin
                  addr_d = bus.m1_addr;
                  dout_d = bus.m1_wdata;
                  rd_d   = ~bus.m1_we;
                  wr_d   = bus.m1_we;
               end else begin
                  addr_d = bus.m0_addr;
                  dout_d = bus.m0_wdata;
                  rd_d   = ~bus.m0_we;
                  wr_d   = bus.m0_we;
               end
            end
         end
         StAccess: begin
            if (bus.io_ready) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
               if (rd_q) begin
                  if (gnt_q) rdata1_d = bus.io_din;
                  else       rdata0_d = bus.io_din;
               end
               ack_d[gnt_q] = 1'b1;
               state_d      = StDone;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rd_d         = 1'b0;
               wr_d         = 1'b0;
               ack_d[gnt_q] = 1'b1;
               err_d[gnt_q] = 1'b1;
               state_d      = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign bus.m0_ack   = ack_q[0];
   assign bus.m0_err   = err_q[0];
   assign bus.m0_rdata = rdata0_q;
   assign bus.m1_ack   = ack_q[1];
   assign bus.m1_err   = err_q[1];
   assign bus.m1_rdata = rdata1_q;
   assign bus.io_rd    = rd_q;
   assign bus.io_wr    = wr_q;
   assign bus.io_addr  = addr_q;
   assign bus.io_dout  = dout_q;
   assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed transaction table, hand-written
// tie/reset sequences, and a randomized run against a transaction-level model.
module tb_io_bus_arbiter;

   localparam int unsigned AW      = 16;
   localparam int unsigned DW      = 16;
   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned CW      = 4;

   logic clk;
   logic reset;
   int   chk_cnt;
   int   pass_cnt;

   io_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   io_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        m;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          delay;
      logic [15:0] din;
      int          exp_lat;
      int          exp_strb;
      logic        exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t tbl [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_req(input logic m, input logic r, input logic we, input logic [15:0] a,
                          input logic [15:0] d);
      if (!m) begin
         bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   task automatic do_reset();
      set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      bus.io_ready = 1'b0;
      bus.io_din   = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int lat, strb, acc, wrong;
      logic err;
      logic [15:0] rdata;
      lat = -1; strb = 0; acc = 0; wrong = 0; err = 1'bx; rdata = 'x;
      set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
      bus.io_ready = 1'b0;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         tick();
         if (bus.io_rd && bus.io_wr) wrong++;
         if (v.we ? bus.io_rd : bus.io_wr) wrong++;
         if ((v.m ? bus.m0_ack : bus.m1_ack) === 1'b1) wrong++;
         if (bus.io_rd || bus.io_wr) begin
            strb++;
            if (bus.io_addr !== v.addr) wrong++;
            if (v.we && bus.io_dout !== v.wdata) wrong++;
            bus.io_ready = (acc == v.delay);
            bus.io_din   = v.din;
            acc++;
         end else begin
            bus.io_ready = 1'b0;
         end
         if ((v.m ? bus.m1_ack : bus.m0_ack) === 1'b1) begin
            lat   = c;
            err   = v.m ? bus.m1_err : bus.m0_err;
            rdata = v.m ? bus.m1_rdata : bus.m0_rdata;
            set_req(v.m, 1'b0, v.we, v.addr, v.wdata);
            bus.io_ready = 1'b0;
         end
      end
      chk($sformatf("row%0d_latency", idx), lat, v.exp_lat);
      chk($sformatf("row%0d_strobe_cycles", idx), strb, v.exp_strb);
      chk($sformatf("row%0d_err", idx), {31'b0, err}, {31'b0, v.exp_err});
      chk($sformatf("row%0d_rdata", idx), {16'b0, rdata}, {16'b0, v.exp_rdata});
      chk($sformatf("row%0d_bus_protocol", idx), wrong, 0);
      tick();
      chk($sformatf("row%0d_busy_after", idx), bus.busy, 1'b0);
   endtask

   // Randomized-phase model state.
   logic        rq [2];
   logic        rwe [2];
   logic [15:0] raddr [2];
   logic [15:0] rwd [2];
   logic [15:0] mrd [2];

   initial begin
      int a0c, a1c, ovl, nack, alt_bad, cnt0, cnt1, first_m;
      logic [15:0] d1, d2;
      logic seen0, seen1, last_m, in_txn, gm, exp_ack, exp_err, exp_m, strobe, a0, a1;
      int acc, dly;
      int order [8];

      chk_cnt = 0;
      pass_cnt = 0;
      do_reset();

      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_strobes", {bus.io_rd, bus.io_wr}, 2'b00);
      chk("reset_io_addr", bus.io_addr, 16'h0);
      chk("reset_io_dout", bus.io_dout, 16'h0);
      chk("reset_acks", {bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err}, 4'h0);
      chk("reset_rdata", {bus.m1_rdata, bus.m0_rdata}, 32'h0);

      tbl[0] = '{1'b0, 1'b0, 16'h4020, 16'h0000, 0,  16'h000A, 2,  1,  1'b0, 16'h000A};
      tbl[1] = '{1'b1, 1'b0, 16'h4010, 16'h0000, 3,  16'h03FF, 5,  4,  1'b0, 16'h03FF};
      tbl[2] = '{1'b0, 1'b0, 16'h4030, 16'h0000, 99, 16'h1234, 16, 15, 1'b1, 16'h000A};
      tbl[3] = '{1'b1, 1'b1, 16'h4002, 16'hBEEF, 1,  16'h5555, 3,  2,  1'b0, 16'h03FF};
      tbl[4] = '{1'b0, 1'b1, 16'h4000, 16'hCAFE, 14, 16'h0000, 16, 15, 1'b0, 16'h000A};
      for (int i = 0; i < 5; i++) run_txn(tbl[i], i);

      // Simultaneous writes from reset: m0 wins the tie, acks at 2 and 5.
      do_reset();
      set_req(1'b0, 1'b1, 1'b1, 16'h4000, 16'h1111);
      set_req(1'b1, 1'b1, 1'b1, 16'h4002, 16'h2222);
      bus.io_ready = 1'b1;
      a0c = -1; a1c = -1; ovl = 0; d1 = 'x; d2 = 'x;
      for (int c = 1; c <= 20 && (a0c < 0 || a1c < 0); c++) begin
         tick();
         if (bus.io_rd || (bus.io_rd && bus.io_wr)) ovl++;
         if (bus.io_wr && c == 1) d1 = bus.io_dout;
         if (bus.io_wr && c == 4) d2 = bus.io_dout;
         if (bus.m0_ack && bus.m1_ack) ovl++;
         if (bus.m0_ack) begin a0c = c; set_req(1'b0, 1'b0, 1'b1, 16'h4000, 16'h1111); end
         if (bus.m1_ack) begin a1c = c; set_req(1'b1, 1'b0, 1'b1, 16'h4002, 16'h2222); end
      end
      chk("tie_m0_ack_cycle", a0c, 2);
      chk("tie_m1_ack_cycle", a1c, 5);
      chk("tie_first_dout", d1, 16'h1111);
      chk("tie_second_dout", d2, 16'h2222);
      chk("tie_overlap", ovl, 0);

      // Continuous requests from both: grants must alternate.
      do_reset();
      set_req(1'b0, 1'b1, 1'b0, 16'h4100, 16'h0);
      set_req(1'b1, 1'b1, 1'b0, 16'h4200, 16'h0);
      bus.io_ready = 1'b1;
      nack = 0;
      for (int c = 1; c <= 60 && nack < 8; c++) begin
         tick();
         if (bus.m0_ack) begin order[nack] = 0; nack++; end
         if (bus.m1_ack && nack < 8) begin order[nack] = 1; nack++; end
      end
      alt_bad = 0; cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < nack; i++) begin
         if (order[i] != (i % 2)) alt_bad++;
         if (order[i] == 0) cnt0++;
         else cnt1++;
      end
      chk("alt_total_acks", nack, 8);
      chk("alt_order", alt_bad, 0);
      chk("alt_m0_acks", cnt0, 4);
      chk("alt_m1_acks", cnt1, 4);

      // Reset during a waited access; afterwards the tie goes to m0 again.
      do_reset();
      set_req(1'b0, 1'b1, 1'b0, 16'h4300, 16'h0);
      for (int i = 0; i < 4; i++) tick();
      chk("rst_mid_in_access", bus.io_rd, 1'b1);
      reset = 1'b1;
      tick();
      chk("rst_mid_io_rd", bus.io_rd, 1'b0);
      chk("rst_mid_busy", bus.busy, 1'b0);
      chk("rst_mid_no_ack", {bus.m1_ack, bus.m0_ack}, 2'b00);
      reset = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 16'h4300, 16'h0);
      set_req(1'b1, 1'b1, 1'b0, 16'h4400, 16'h0);
      bus.io_ready = 1'b1;
      bus.io_din = 16'h0077;
      first_m = -1; a1c = -1;
      for (int c = 1; c <= 20 && a1c < 0; c++) begin
         tick();
         if (bus.m0_ack) begin
            if (first_m < 0) first_m = 0;
            set_req(1'b0, 1'b0, 1'b0, 16'h4300, 16'h0);
         end
         if (bus.m1_ack) begin
            if (first_m < 0) first_m = 1;
            a1c = c;
            d1 = bus.m1_rdata;
            set_req(1'b1, 1'b0, 1'b0, 16'h4400, 16'h0);
         end
      end
      chk("rst_after_first_grant", first_m, 0);
      chk("rst_after_m1_ack_cycle", a1c, 5);
      chk("rst_after_m1_rdata", d1, 16'h0077);

      // Randomized traffic against a transaction-level model.
      do_reset();
      for (int m = 0; m < 2; m++) begin
         rq[m] = 1'b0; rwe[m] = 1'b0; raddr[m] = '0; rwd[m] = '0; mrd[m] = '0;
      end
      seen0 = 1'b0; seen1 = 1'b0; last_m = 1'b1; in_txn = 1'b0; gm = 1'b0;
      exp_ack = 1'b0; exp_err = 1'b0; exp_m = 1'b0; acc = 0; dly = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         a0 = bus.m0_ack;
         a1 = bus.m1_ack;
         strobe = bus.io_rd | bus.io_wr;
         chk("rnd_exclusive", bus.io_rd & bus.io_wr, 1'b0);
         if (exp_ack) begin
            chk("rnd_ack", {a1, a0}, exp_m ? 2'b10 : 2'b01);
            chk("rnd_err", exp_m ? bus.m1_err : bus.m0_err, exp_err);
            chk("rnd_rdata", exp_m ? bus.m1_rdata : bus.m0_rdata, mrd[exp_m]);
            chk("rnd_strobe_dropped", strobe, 1'b0);
            exp_ack = 1'b0;
         end else begin
            chk("rnd_no_ack", {a1, a0}, 2'b00);
         end
         if (strobe && !in_txn) begin
            chk("rnd_grant_had_req", seen0 | seen1, 1'b1);
            gm = (seen0 && seen1) ? ~last_m : seen1;
            last_m = gm;
            chk("rnd_grant_dir", {bus.io_wr, bus.io_rd}, rwe[gm] ? 2'b10 : 2'b01);
            if (rwe[gm]) chk("rnd_grant_dout", bus.io_dout, rwd[gm]);
            in_txn = 1'b1;
            acc = 0;
            dly = $urandom_range(0, 17);
         end
         if (in_txn && strobe) begin
            chk("rnd_addr", bus.io_addr, raddr[gm]);
            bus.io_din = 16'($urandom);
            if (acc == dly) begin
               bus.io_ready = 1'b1;
               exp_ack = 1'b1; exp_err = 1'b0; exp_m = gm; in_txn = 1'b0;
               if (!rwe[gm]) mrd[gm] = bus.io_din;
            end else begin
               bus.io_ready = 1'b0;
               if (acc == int'(TIMEOUT) - 1) begin
                  exp_ack = 1'b1; exp_err = 1'b1; exp_m = gm; in_txn = 1'b0;
               end
            end
            acc++;
         end else if (in_txn) begin
            chk("rnd_strobe_held", strobe, 1'b1);
            in_txn = 1'b0;
         end else begin
            bus.io_ready = 1'($urandom);
            bus.io_din = 16'($urandom);
         end
         for (int m = 0; m < 2; m++) begin
            if ((m == 0 && a0) || (m == 1 && a1)) begin
               rq[m] = 1'b0;
            end else if (!rq[m] && $urandom_range(0, 3) == 0) begin
               rq[m] = 1'b1;
               rwe[m] = 1'($urandom);
               raddr[m] = 16'($urandom);
               rwd[m] = 16'($urandom);
            end
            set_req(m[0], rq[m], rwe[m], raddr[m], rwd[m]);
         end
         seen0 = rq[0];
         seen1 = rq[1];
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
